// File: rtl/waveform_player.sv
// waveform_player
//   Plays samples out of a 256x8 waveform ROM. A start pulse begins playback. The player
//   walks the ROM from address 0 by a programmable step. Between samples it waits a
//   programmable number of idle cycles. Each ROM word is presented on a valid/ready
//   stream. Playback is either one-shot (ends on the first address carry) or a continuous
//   loop (the address wraps modulo 2^ADDR_W). A stop pulse aborts playback at any time.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   start         1-cycle pulse, begins playback (only honoured while idle)
//   stop          1-cycle pulse, aborts playback and returns to idle
//   loop_en       1 = wrap and keep playing, 0 = one-shot; sampled live at each carry
//   step          address increment, latched at start (0 behaves as 1)
//   div           idle cycles between samples, latched at start
//   rom_addr      registered ROM address
//   rom_data      ROM word at rom_addr (combinational ROM)
//   sample        registered sample
//   sample_valid  sample holds data
//   sample_ready  consumer accepts sample when sample_valid && sample_ready
//   busy          high whenever not idle
//   done          1-cycle pulse when a one-shot pass ends
module waveform_player #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] step,
  input  logic [DIV_W-1:0]  div,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StEmit = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [ADDR_W-1:0] StepOne = ADDR_W'(1);
  localparam logic [DIV_W-1:0]  CntOne  = DIV_W'(1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              valid_q, valid_d;

  // One extra bit so the carry out of the address tells us a pass has ended.
  logic [ADDR_W:0]   nxt;
  logic              handshake;

  assign nxt       = {1'b0, addr_q} + {1'b0, step_q};
  assign handshake = valid_q && sample_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    step_d   = step_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    valid_d  = valid_q;

    unique case (state_q)
      StIdle: begin
        // start together with stop is treated as no request.
        if (start && !stop) begin
          step_d  = (step == '0) ? StepOne : step;
          div_d   = div;
          addr_d  = '0;
          cnt_d   = div;
          state_d = StWait;
        end
      end

      StWait: begin
        if (stop) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          sample_d = rom_data;
          valid_d  = 1'b1;
          state_d  = StEmit;
        end
      end

      StEmit: begin
        // stop wins over a simultaneous handshake: the consumer still takes that
        // sample, but playback ends without a done pulse.
        if (stop) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (handshake) begin
          valid_d = 1'b0;
          if (nxt[ADDR_W] && !loop_en) begin
            state_d = StDone;
          end else begin
            addr_d  = nxt[ADDR_W-1:0];
            cnt_d   = div_q;
            state_d = StWait;
          end
        end
      end

      StDone: begin
        // rom_addr deliberately keeps the last played address.
        valid_d = 1'b0;
        state_d = StIdle;
      end

      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      step_q   <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      step_q   <= step_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign rom_addr     = addr_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != StIdle);
  // A stop arriving in the done cycle suppresses the pulse.
  assign done         = (state_q == StDone) && !stop;

endmodule

// File: tb/tb_waveform_player.sv
// Scoreboard bench for waveform_player. The stimulus process pushes expected ROM
// addresses; a monitor pops and compares on every valid&&ready handshake.
module tb_waveform_player;

  logic       clk = 1'b0;
  logic       reset, start, stop, loop_en;
  logic [7:0] step, div;
  logic [7:0] rom_addr, rom_data, sample;
  logic       sample_valid, sample_ready, busy, done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int cyc = 0;
  int last_hs = 0;
  bit first_hs = 1'b1;
  int exp_period = 0;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    logic [7:0] p;
    p = a * 8'd29;
    return p ^ 8'h5A;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  waveform_player #(.ADDR_W(8), .DATA_W(8), .DIV_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .step(step), .div(div), .rom_addr(rom_addr), .rom_data(rom_data),
    .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: consumes the scoreboard on each handshake, checks spacing, counts done.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (sample_valid && sample_ready && !reset) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("addr", int'(rom_addr), int'(e));
          check("sample", int'(sample), int'(rom_fn(e)));
        end
        if (!first_hs && exp_period != 0) check("period", cyc - last_hs, exp_period);
        last_hs  = cyc;
        first_hs = 1'b0;
        hs_cnt++;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (busy && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  task automatic wait_valid(input int max, input string name);
    int n = 0;
    while (!sample_valid && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, int'(sample_valid), 1);
  endtask

  task automatic setup(input logic [7:0] s, input logic [7:0] d, input logic lp,
                       input logic rdy, input int per);
    step = s;
    div = d;
    loop_en = lp;
    sample_ready = rdy;
    exp_period = per;
    first_hs = 1'b1;
  endtask

  initial begin
    int d0, h0, n;
    reset = 1'b1; start = 1'b1; stop = 1'b0; loop_en = 1'b0;
    step = 8'd0; div = 8'd0; sample_ready = 1'b0;

    // 1: reset for two cycles with start held high
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", int'(rom_addr), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0; start = 1'b0;
    @(posedge clk);
    #1 check("post_rst_busy", int'(busy), 0);

    // 2: step=1, div=0, one-shot: all 256 words, valid every 2 cycles
    setup(8'd1, 8'd0, 1'b0, 1'b1, 2);
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    d0 = done_cnt; h0 = hs_cnt;
    pulse_start();
    wait_idle(2000, "t2_idle");
    check("t2_done", done_cnt - d0, 1);
    check("t2_count", hs_cnt - h0, 256);
    check("t2_left", exp_q.size(), 0);
    check("t2_last_addr", int'(rom_addr), 255);

    // 3a: step=3 one-shot: 86 samples, last at 255
    setup(8'd3, 8'd0, 1'b0, 1'b1, 2);
    for (int k = 0; k < 86; k++) exp_q.push_back(8'(k * 3));
    d0 = done_cnt; h0 = hs_cnt;
    pulse_start();
    wait_idle(1000, "t3_idle");
    check("t3_done", done_cnt - d0, 1);
    check("t3_count", hs_cnt - h0, 86);
    check("t3_left", exp_q.size(), 0);

    // 3b: step=0 behaves as step=1
    setup(8'd0, 8'd0, 1'b0, 1'b1, 2);
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
    d0 = done_cnt; h0 = hs_cnt;
    pulse_start();
    wait_idle(2000, "t3b_idle");
    check("t3b_done", done_cnt - d0, 1);
    check("t3b_count", hs_cnt - h0, 256);

    // 4a: step=64 looping, then stop while waiting
    setup(8'd64, 8'd5, 1'b1, 1'b1, 7);
    exp_q.push_back(8'd0);   exp_q.push_back(8'd64);
    exp_q.push_back(8'd128); exp_q.push_back(8'd192);
    exp_q.push_back(8'd0);   exp_q.push_back(8'd64);
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("t4_drained", exp_q.size(), 0);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    check("t4_stop_busy", int'(busy), 0);
    check("t4_stop_valid", int'(sample_valid), 0);
    repeat (3) @(posedge clk);
    #1 check("t4_no_done", done_cnt - d0, 0);

    // 4b: loop_en dropped after the first wrap ends at the second carry
    setup(8'd64, 8'd1, 1'b1, 1'b1, 3);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) exp_q.push_back(8'(k * 64));
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (exp_q.size() > 4 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1 loop_en = 1'b0;
    wait_idle(200, "t4b_idle");
    check("t4b_done", done_cnt - d0, 1);
    check("t4b_left", exp_q.size(), 0);

    // 5: div=3, ready low for 6 cycles while valid
    setup(8'd128, 8'd3, 1'b0, 1'b0, 5);
    exp_q.push_back(8'd0); exp_q.push_back(8'd128);
    d0 = done_cnt; h0 = hs_cnt;
    pulse_start();
    repeat (3) @(posedge clk);
    #1 check("t5_valid_early", int'(sample_valid), 0);
    @(posedge clk);
    #1 check("t5_valid_first", int'(sample_valid), 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("t5_hold_valid", int'(sample_valid), 1);
      check("t5_hold_addr", int'(rom_addr), 0);
      check("t5_hold_sample", int'(sample), int'(rom_fn(8'd0)));
    end
    sample_ready = 1'b1;
    wait_idle(200, "t5_idle");
    check("t5_done", done_cnt - d0, 1);
    check("t5_count", hs_cnt - h0, 2);

    // 6a: start while busy is ignored
    setup(8'd16, 8'd2, 1'b0, 1'b1, 4);
    for (int k = 0; k < 16; k++) exp_q.push_back(8'(k * 16));
    d0 = done_cnt; h0 = hs_cnt;
    pulse_start();
    repeat (20) @(posedge clk);
    #1 step = 8'd1; div = 8'd0;
    pulse_start();
    check("t6_still_busy", int'(busy), 1);
    wait_idle(300, "t6_idle");
    check("t6_done", done_cnt - d0, 1);
    check("t6_count", hs_cnt - h0, 16);
    check("t6_left", exp_q.size(), 0);

    // 6b: reset while a sample is held in EMIT
    setup(8'd1, 8'd0, 1'b1, 1'b1, 2);
    for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
    d0 = done_cnt;
    pulse_start();
    repeat (5) @(posedge clk);
    #1 sample_ready = 1'b0;
    wait_valid(20, "t6b_valid");
    check("t6b_addr_before", int'(rom_addr), 2);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("t6b_addr", int'(rom_addr), 0);
    check("t6b_sample", int'(sample), 0);
    check("t6b_valid", int'(sample_valid), 0);
    check("t6b_busy", int'(busy), 0);
    check("t6b_done", int'(done), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 check("t6b_no_done", done_cnt - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
